ux607_gpio_in_sampler: RTL and testbench
========================================

UX607_GPIO_IN_SAMPLER -- requirements
Module: ux607_gpio_in_sampler

Interface
REQ-001 Parameter WIDTH, default 8: number of input pins.
REQ-002 Parameter DEB_W, default 4: debounce counter width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 io_pin  input  WIDTH  asynchronous external pin levels.
REQ-007 io_deb_limit  input  DEB_W  debounce hold count L, shared by all bits.
REQ-008 io_rise_ie  input  WIDTH  per-bit rising-edge pending enable.
REQ-009 io_fall_ie  input  WIDTH  per-bit falling-edge pending enable.
REQ-010 io_clr_en  input  1  write-1-to-clear strobe for pending bits.
REQ-011 io_clr_mask  input  WIDTH  bits to clear when io_clr_en=1.
REQ-012 io_value  output  WIDTH  debounced, synchronized pin value.
REQ-013 io_rise_ip  output  WIDTH  rising-edge pending flags.
REQ-014 io_fall_ip  output  WIDTH  falling-edge pending flags.
REQ-015 io_irq  output  1  OR of all io_rise_ip and io_fall_ip bits.

Function
REQ-016 Each io_pin bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-017 Per bit, a stable register and a DEB_W-bit counter SHALL be kept; io_value SHALL equal the stable registers.
REQ-018 If s2 equals stable, the counter SHALL clear to 0.
REQ-019 If s2 differs from stable and counter >= io_deb_limit, stable SHALL load s2 and the counter SHALL clear.
REQ-020 If s2 differs from stable and counter < io_deb_limit, the counter SHALL increment by 1, saturating at all-ones.
REQ-021 Latency: a pin level held from before clock edge k SHALL appear on io_value after edge k+2+L; a pulse shorter than L+1 cycles at s2 SHALL NOT change io_value.
REQ-022 L=0 SHALL give pure synchronizer behaviour (3-edge latency, no filtering).
REQ-023 Lowering io_deb_limit mid-count SHALL take effect next cycle via the >= compare, with no counter wrap.
REQ-024 A stable 0->1 update SHALL set io_rise_ip[i] when io_rise_ie[i]=1; a 1->0 update SHALL set io_fall_ip[i] when io_fall_ie[i]=1.
REQ-025 io_clr_en=1 SHALL clear io_rise_ip and io_fall_ip bits selected by io_clr_mask on the next edge.
REQ-026 When set and clear hit the same bit in the same cycle, set SHALL win.
REQ-027 Clearing the ie bits SHALL NOT clear already-pending ip bits.
REQ-028 io_irq SHALL be combinational from the ip registers (zero added latency).

Reset
REQ-029 With reset=1 at an edge, s1, s2, stable, counters, io_rise_ip and io_fall_ip SHALL all become 0; io_value=0 and io_irq=0.
REQ-030 A pin high at reset release SHALL be treated as a 0->1 change (rise pending after 2+L edges if enabled).
REQ-031 Reset asserted mid-debounce SHALL discard the count with no edge reported.

Structure
REQ-032 Package ux607_gpio_in_pkg SHALL hold WIDTH and DEB_W defaults and the synchronizer depth constant (2).
REQ-033 Sub-module ux607_gpio_in_bit SHALL implement one bit (sync, debounce, edge set/clear), instantiated WIDTH times.

Verification
REQ-034 L=0, io_rise_ie=0xFF, pin0 0->1 before edge 10 -> io_value[0]=1 after edge 12, io_rise_ip=0x01, io_irq=1.
REQ-035 L=3, pin1 high for 3 cycles then low -> io_value unchanged, no ip set; held 5 cycles -> io_value[1]=1 after edge k+5.
REQ-036 io_fall_ip=0x04 pending, io_clr_en=1 with mask 0x04 in the same cycle as a new fall on bit 2 -> io_fall_ip stays 0x04.
REQ-037 io_clr_en=1, mask 0xFF with ip=0x81 and no new edges -> ip=0x00 next cycle, io_irq=0.
REQ-038 Pins held 0xA5 through reset, reset released at edge 5, L=1, all ie=1 -> io_value=0xA5 after edge 8, io_rise_ip=0xA5.
REQ-039 L=15, counter at 9, io_deb_limit changed to 4 -> stable updates on the next edge.

Source files
------------

// File: rtl/ux607_gpio_in_pkg.sv
// Shared constants and types for the UX607 GPIO input sampler.
// Holds the default geometry, the synchronizer depth and the debounce action encoding.
package ux607_gpio_in_pkg;

    localparam int unsigned GPIO_WIDTH      = 8;
    localparam int unsigned GPIO_DEB_W      = 4;
    localparam int unsigned GPIO_SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        DEB_CLEAR = 2'd0,
        DEB_COUNT = 2'd1,
        DEB_LOAD  = 2'd2
    } deb_act_e;

endpackage

// File: rtl/ux607_gpio_in_bit.sv
// One GPIO input bit: two-flop synchronizer, hold-count debouncer and
// rise/fall pending flags with write-1-to-clear (a new set beats a clear).
module ux607_gpio_in_bit
    import ux607_gpio_in_pkg::*;
#(
    parameter int unsigned DEB_W = GPIO_DEB_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_pin,
    input  logic [DEB_W-1:0] i_deb_limit,
    input  logic             i_rise_ie,
    input  logic             i_fall_ie,
    input  logic             i_clr,
    output logic             o_value,
    output logic             o_rise_ip,
    output logic             o_fall_ip
);

    logic [GPIO_SYNC_DEPTH-1:0] r_sync;
    logic                       r_stable;
    logic [DEB_W-1:0]           r_cnt;
    logic                       r_rise_ip;
    logic                       r_fall_ip;
    logic                       w_s2;
    deb_act_e                   w_act;
    logic                       w_rise_set;
    logic                       w_fall_set;

    assign w_s2 = r_sync[GPIO_SYNC_DEPTH-1];

    // Synchronizer shift chain for the asynchronous pin.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[GPIO_SYNC_DEPTH-2:0], i_pin};
        end
    end

    // Debounce decision; >= lets a lowered limit take effect immediately.
    always_comb begin
        w_act      = DEB_CLEAR;
        w_rise_set = 1'b0;
        w_fall_set = 1'b0;
        if (w_s2 == r_stable) begin
            w_act = DEB_CLEAR;
        end else if (r_cnt >= i_deb_limit) begin
            w_act      = DEB_LOAD;
            w_rise_set = w_s2 & i_rise_ie;
            w_fall_set = ~w_s2 & i_fall_ie;
        end else begin
            w_act = DEB_COUNT;
        end
    end

    // Stable value and hold counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (w_act)
                DEB_CLEAR: r_cnt <= '0;
                DEB_LOAD: begin
                    r_stable <= w_s2;
                    r_cnt    <= '0;
                end
                DEB_COUNT: r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + DEB_W'(1);
                default:   r_cnt <= '0;
            endcase
        end
    end

    // Pending flags: set has priority over the clear strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rise_ip <= 1'b0;
            r_fall_ip <= 1'b0;
        end else begin
            r_rise_ip <= w_rise_set | (r_rise_ip & ~i_clr);
            r_fall_ip <= w_fall_set | (r_fall_ip & ~i_clr);
        end
    end

    assign o_value   = r_stable;
    assign o_rise_ip = r_rise_ip;
    assign o_fall_ip = r_fall_ip;

endmodule

// File: rtl/ux607_gpio_in_sampler.sv
// GPIO input sampler top: WIDTH independent debounced bits sharing one hold
// count, with a combined interrupt formed directly from the pending flags.
module ux607_gpio_in_sampler
    import ux607_gpio_in_pkg::*;
#(
    parameter int unsigned WIDTH = GPIO_WIDTH,
    parameter int unsigned DEB_W = GPIO_DEB_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_pin,
    input  logic [DEB_W-1:0] io_deb_limit,
    input  logic [WIDTH-1:0] io_rise_ie,
    input  logic [WIDTH-1:0] io_fall_ie,
    input  logic             io_clr_en,
    input  logic [WIDTH-1:0] io_clr_mask,
    output logic [WIDTH-1:0] io_value,
    output logic [WIDTH-1:0] io_rise_ip,
    output logic [WIDTH-1:0] io_fall_ip,
    output logic             io_irq
);

    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rise_ip;
    logic [WIDTH-1:0] w_fall_ip;

    assign w_clr = {WIDTH{io_clr_en}} & io_clr_mask;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ux607_gpio_in_bit #(
            .DEB_W (DEB_W)
        ) u_bit (
            .clock       (clock),
            .reset       (reset),
            .i_pin       (io_pin[i]),
            .i_deb_limit (io_deb_limit),
            .i_rise_ie   (io_rise_ie[i]),
            .i_fall_ie   (io_fall_ie[i]),
            .i_clr       (w_clr[i]),
            .o_value     (io_value[i]),
            .o_rise_ip   (w_rise_ip[i]),
            .o_fall_ip   (w_fall_ip[i])
        );
    end

    assign io_rise_ip = w_rise_ip;
    assign io_fall_ip = w_fall_ip;
    assign io_irq     = |(w_rise_ip | w_fall_ip);

endmodule

// File: tb/tb_ux607_gpio_in_sampler.sv
// Scoreboard bench for ux607_gpio_in_sampler: directed pin sequences queue
// cycle-tagged expectations that a negedge monitor pops and compares.
module tb_ux607_gpio_in_sampler;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] io_pin;
    logic [3:0] io_deb_limit;
    logic [7:0] io_rise_ie;
    logic [7:0] io_fall_ie;
    logic       io_clr_en;
    logic [7:0] io_clr_mask;
    logic [7:0] io_value;
    logic [7:0] io_rise_ip;
    logic [7:0] io_fall_ip;
    logic       io_irq;

    typedef struct {
        int         at;
        logic [7:0] value;
        logic [7:0] rise;
        logic [7:0] fall;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    ux607_gpio_in_sampler #(.WIDTH(8), .DEB_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_pin       (io_pin),
        .io_deb_limit (io_deb_limit),
        .io_rise_ie   (io_rise_ie),
        .io_fall_ie   (io_fall_ie),
        .io_clr_en    (io_clr_en),
        .io_clr_mask  (io_clr_mask),
        .io_value     (io_value),
        .io_rise_ip   (io_rise_ip),
        .io_fall_ip   (io_fall_ip),
        .io_irq       (io_irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic push(input int at, input logic [7:0] v, input logic [7:0] r,
                        input logic [7:0] f, input string n);
        exp_t e;
        e.at = at; e.value = v; e.rise = r; e.fall = f; e.name = n;
        q.push_back(e);
    endtask

    // Advance until just after edge n.
    task automatic after(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: compare every expectation due at the current edge.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            logic eirq;
            e = q.pop_front();
            eirq = |(e.rise | e.fall);
            n_tests++;
            if (e.at < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for edge %0d not checked until edge %0d", e.name, e.at, cyc);
            end else if (io_value !== e.value || io_rise_ip !== e.rise ||
                         io_fall_ip !== e.fall || io_irq !== eirq) begin
                n_fail++;
                $display("FAIL %s @edge %0d: got value=%h rise=%h fall=%h irq=%b, want value=%h rise=%h fall=%h irq=%b",
                         e.name, cyc, io_value, io_rise_ip, io_fall_ip, io_irq,
                         e.value, e.rise, e.fall, eirq);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run exceeded time limit at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        io_pin       = 8'hA5;
        io_deb_limit = 4'd1;
        io_rise_ie   = 8'hFF;
        io_fall_ie   = 8'hFF;
        io_clr_en    = 1'b0;
        io_clr_mask  = 8'h00;

        // Pins held through reset, released so edge 5 is the first live edge.
        push(3, 8'h00, 8'h00, 8'h00, "reset_state");
        push(4, 8'h00, 8'h00, 8'h00, "reset_state_hold");
        push(7, 8'h00, 8'h00, 8'h00, "l1_one_early");
        push(8, 8'hA5, 8'hA5, 8'h00, "reset_release_rise");
        after(4);
        reset = 1'b0;

        after(8);
        io_clr_en = 1'b1; io_clr_mask = 8'hFF;
        push(9, 8'hA5, 8'h00, 8'h00, "clr_all_a5");

        // Start a long debounce, then reset in the middle of it.
        after(9);
        io_clr_en = 1'b0; io_pin = 8'h00; io_deb_limit = 4'd15;
        push(13, 8'hA5, 8'h00, 8'h00, "mid_debounce");
        push(14, 8'h00, 8'h00, 8'h00, "reset_mid_debounce");
        after(13);
        reset = 1'b1;
        after(14);
        reset = 1'b0;
        push(20, 8'h00, 8'h00, 8'h00, "no_edge_after_reset");

        // L=0: pure synchronizer latency.
        after(20);
        io_deb_limit = 4'd0; io_pin = 8'h01;
        push(22, 8'h00, 8'h00, 8'h00, "l0_one_early");
        push(23, 8'h01, 8'h01, 8'h00, "l0_rise");
        after(23);
        io_pin = 8'h81;
        push(26, 8'h81, 8'h81, 8'h00, "rise_bit7");
        after(26);
        io_clr_en = 1'b1; io_clr_mask = 8'hFF;
        push(27, 8'h81, 8'h00, 8'h00, "clr_ff_irq_low");

        // Build a pending fall on bit 2, then re-fire it while clearing.
        after(27);
        io_clr_en = 1'b0; io_pin = 8'h85;
        push(30, 8'h85, 8'h04, 8'h00, "rise_bit2");
        push(33, 8'h81, 8'h04, 8'h04, "fall_bit2");
        after(30);
        io_pin = 8'h81;
        after(33);
        io_pin = 8'h85;
        push(36, 8'h85, 8'h04, 8'h04, "rise_bit2_again");
        after(36);
        io_pin = 8'h81;
        after(38);
        io_clr_en = 1'b1; io_clr_mask = 8'h04;
        push(39, 8'h81, 8'h00, 8'h04, "set_wins_over_clr");

        // Disabling ie keeps pending flags and blocks new ones.
        after(39);
        io_clr_en = 1'b0; io_rise_ie = 8'h00; io_fall_ie = 8'h00; io_pin = 8'h80;
        push(41, 8'h81, 8'h00, 8'h04, "ie_off_keeps_ip");
        push(42, 8'h80, 8'h00, 8'h04, "ie_off_no_set");
        after(42);
        io_clr_en = 1'b1; io_clr_mask = 8'hFF;
        push(43, 8'h80, 8'h00, 8'h00, "clr_fall");

        // L=3: a 3-cycle glitch is filtered, a held level passes after L+2.
        after(43);
        io_clr_en = 1'b0; io_rise_ie = 8'hFF; io_fall_ie = 8'hFF;
        io_deb_limit = 4'd3; io_pin = 8'h82;
        push(50, 8'h80, 8'h00, 8'h00, "glitch_filtered");
        after(46);
        io_pin = 8'h80;
        after(50);
        io_pin = 8'h82;
        push(55, 8'h80, 8'h00, 8'h00, "l3_one_early");
        push(56, 8'h82, 8'h02, 8'h00, "l3_rise");

        // L=15 counting to 9, then the limit drops to 4.
        after(56);
        io_deb_limit = 4'd15; io_pin = 8'h80;
        push(67, 8'h82, 8'h02, 8'h00, "l15_counting");
        push(68, 8'h80, 8'h02, 8'h02, "limit_lowered");
        after(67);
        io_deb_limit = 4'd4;

        after(72);
        @(posedge clock);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for edge %0d never checked", e.name, e.at);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
